// File: rtl/serial_link_lane_deskew_if.sv
// Lane-side and word-side signals of the lane deskew buffer, grouped for port use.
// Signal names keep their direction suffixes as seen from the deskew block (slave side).
interface serial_link_lane_deskew_if #(
  parameter int NumLanes  = 8,
  parameter int LaneWidth = 1,
  parameter int Depth     = 4
);
  localparam int CntW = $clog2(Depth + 1);

  logic                          flush_i;
  logic [NumLanes-1:0]           lane_valid_i;
  logic [NumLanes*LaneWidth-1:0] lane_data_i;
  logic [NumLanes*LaneWidth-1:0] data_o;
  logic                          valid_o;
  logic                          ready_i;
  logic                          overflow_o;
  logic [CntW-1:0]               max_skew_o;

  modport master (
    output flush_i, lane_valid_i, lane_data_i, ready_i,
    input  data_o, valid_o, overflow_o, max_skew_o
  );

  modport slave (
    input  flush_i, lane_valid_i, lane_data_i, ready_i,
    output data_o, valid_o, overflow_o, max_skew_o
  );
endinterface

// File: rtl/serial_link_lane_deskew.sv
// Receive lane deskew: per-lane FIFOs realign skewed lane beats into full-width words.
// Optional skew statistics on max_skew_o when SERIAL_LINK_DESKEW_STATS_EN is defined.
module serial_link_lane_deskew #(
  parameter int NumLanes  = 8,
  parameter int LaneWidth = 1,
  parameter int Depth     = 4
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  serial_link_lane_deskew_if.slave link
);
  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic {ST_RUN, ST_ERROR} state_e;

  state_e                        r_state, w_state_nxt;
  logic [CntW-1:0]               r_fill [NumLanes];
  logic [PtrW-1:0]               r_wptr [NumLanes];
  logic [PtrW-1:0]               r_rptr;
  logic [LaneWidth-1:0]          r_mem  [NumLanes][Depth];

  logic [NumLanes-1:0]           w_nonempty, w_full, w_push;
  logic [NumLanes*LaneWidth-1:0] w_head, w_data;
  logic                          w_run, w_valid, w_pop, w_ovf, w_overflow;

  function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pops are common to every lane, so a single read pointer addresses all heads.
  always_comb begin
    w_nonempty = '0;
    w_full     = '0;
    w_head     = '0;
    for (int l = 0; l < NumLanes; l++) begin
      w_nonempty[l] = (r_fill[l] != '0);
      w_full[l]     = (r_fill[l] == CntW'(Depth));
      w_head[l*LaneWidth +: LaneWidth] = r_mem[l][r_rptr];
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_valid = w_run & (&w_nonempty);
  assign w_pop   = w_valid & link.ready_i & ~link.flush_i;
  assign w_push  = link.lane_valid_i & {NumLanes{w_run & ~link.flush_i}} & (~w_full | {NumLanes{w_pop}});
  assign w_ovf   = w_run & ~link.flush_i & ~w_pop & (|(link.lane_valid_i & w_full));

  always_comb begin
    w_state_nxt = r_state;
    w_data      = '0;
    w_overflow  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_valid) w_data = w_head;
        if (w_ovf) w_state_nxt = ST_ERROR;
      end
      ST_ERROR: begin
        w_overflow = 1'b1;
        if (link.flush_i) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign link.valid_o    = w_valid;
  assign link.data_o     = w_data;
  assign link.overflow_o = w_overflow;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr <= '0;
      for (int l = 0; l < NumLanes; l++) begin
        r_wptr[l] <= '0;
        r_fill[l] <= '0;
      end
    end else if (link.flush_i) begin
      r_rptr <= '0;
      for (int l = 0; l < NumLanes; l++) begin
        r_wptr[l] <= '0;
        r_fill[l] <= '0;
      end
    end else begin
      if (w_pop) r_rptr <= f_inc(r_rptr);
      for (int l = 0; l < NumLanes; l++) begin
        if (w_push[l]) r_wptr[l] <= f_inc(r_wptr[l]);
        case ({w_push[l], w_pop})
          2'b10:   r_fill[l] <= r_fill[l] + 1'b1;
          2'b01:   r_fill[l] <= r_fill[l] - 1'b1;
          default: r_fill[l] <= r_fill[l];
        endcase
      end
    end
  end

  // NOTE: payload storage has no reset; fill counters alone decide what is visible.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NumLanes; l++) begin
      if (w_push[l]) r_mem[l][r_wptr[l]] <= link.lane_data_i[l*LaneWidth +: LaneWidth];
    end
  end

`ifdef SERIAL_LINK_DESKEW_STATS_EN
  logic [CntW-1:0] w_fill_max, w_fill_min, w_skew, r_max_skew;

  always_comb begin
    w_fill_max = '0;
    w_fill_min = CntW'(Depth);
    for (int l = 0; l < NumLanes; l++) begin
      if (r_fill[l] > w_fill_max) w_fill_max = r_fill[l];
      if (r_fill[l] < w_fill_min) w_fill_min = r_fill[l];
    end
    w_skew = w_fill_max - w_fill_min;
  end

  // Fills never exceed Depth, so the running maximum saturates at Depth by construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   r_max_skew <= '0;
    else if (link.flush_i)         r_max_skew <= '0;
    else if (w_skew > r_max_skew)  r_max_skew <= w_skew;
  end

  assign link.max_skew_o = r_max_skew;
`else
  assign link.max_skew_o = '0;
`endif
endmodule

// File: tb/tb_serial_link_lane_deskew.sv
// Scoreboard bench for serial_link_lane_deskew: queue-based lane model, randomized and directed traffic.
module tb_serial_link_lane_deskew;
  localparam int NL    = 8;
  localparam int LW    = 1;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DW    = NL * LW;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  serial_link_lane_deskew_if #(.NumLanes(NL), .LaneWidth(LW), .Depth(DEPTH)) bus ();

  serial_link_lane_deskew #(.NumLanes(NL), .LaneWidth(LW), .Depth(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .link   (bus)
  );

  typedef struct packed {
    logic          valid;
    logic          ovf;
    logic [CW-1:0] skew;
  } status_t;

  status_t       status_q[$];
  logic [DW-1:0] word_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [LW-1:0] mq [NL][$];
  bit            m_err;
  int            m_skew;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < NL; l++) mq[l].delete();
    m_err  = 1'b0;
    m_skew = 0;
  endtask

  // One clock of stimulus; the model predicts this cycle's outputs, then advances its lane queues.
  task automatic step(input logic [NL-1:0] lv, input logic [DW-1:0] ld,
                      input logic rdy, input logic fl);
    bit            all_ne;
    bit            take;
    logic [DW-1:0] w;
    int            mx, mn;
    status_t       s;
    @(posedge clk);
    #1;
    bus.lane_valid_i = lv;
    bus.lane_data_i  = ld;
    bus.ready_i      = rdy;
    bus.flush_i      = fl;
    all_ne = 1'b1;
    w      = '0;
    mx     = 0;
    mn     = DEPTH;
    for (int l = 0; l < NL; l++) begin
      if (mq[l].size() == 0) all_ne = 1'b0;
      else w[l*LW +: LW] = mq[l][0];
      if (mq[l].size() > mx) mx = mq[l].size();
      if (mq[l].size() < mn) mn = mq[l].size();
    end
    s.valid = !m_err && all_ne;
    s.ovf   = m_err;
`ifdef SERIAL_LINK_DESKEW_STATS_EN
    s.skew  = CW'(m_skew);
`else
    s.skew  = '0;
`endif
    status_q.push_back(s);
    take = s.valid && rdy && !fl;
    if (take) word_q.push_back(w);
    if (fl) begin
      model_clear();
    end else begin
      if (mx - mn > m_skew) m_skew = mx - mn;
      if (!m_err) begin
        for (int l = 0; l < NL; l++) begin
          if (take) void'(mq[l].pop_front());
        end
        for (int l = 0; l < NL; l++) begin
          if (lv[l]) begin
            if (mq[l].size() < DEPTH) mq[l].push_back(ld[l*LW +: LW]);
            else m_err = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, '0, rdy, 1'b0);
  endtask

  // Continuous stream of len beats per lane; lane lead_lane starts first, the rest lead cycles later.
  // lead_lane < 0 picks a random start offset per lane.
  task automatic stream(input int lead_lane, input int lead, input int len, input bit rnd_ready);
    int            d [NL];
    logic [NL-1:0] lv;
    logic          rdy;
    for (int l = 0; l < NL; l++)
      d[l] = (lead_lane < 0) ? int'($urandom_range(0, DEPTH - 1)) : ((l == lead_lane) ? 0 : lead);
    for (int t = 0; t < len + DEPTH + 2; t++) begin
      lv = '0;
      for (int l = 0; l < NL; l++)
        if (t >= d[l] && t < d[l] + len) lv[l] = 1'b1;
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(lv, DW'($urandom), rdy, 1'b0);
    end
  endtask

  // Monitor: per-cycle status from the status queue, accepted words from the word queue.
  always @(negedge clk) begin
    status_t s;
    if (rst_ni) begin
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        check("valid_o", 32'(bus.valid_o), 32'(s.valid));
        check("overflow_o", 32'(bus.overflow_o), 32'(s.ovf));
        check("max_skew_o", 32'(bus.max_skew_o), 32'(s.skew));
        if (!bus.valid_o) check("data_o_idle_zero", 32'(bus.data_o), 32'd0);
      end
      if (bus.valid_o && bus.ready_i && !bus.flush_i) begin
        if (word_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none at t=%0t", bus.data_o, $time);
        end else begin
          check("word", 32'(bus.data_o), 32'(word_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.lane_valid_i = '0;
    bus.lane_data_i  = '0;
    bus.ready_i      = 1'b0;
    bus.flush_i      = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_data_o", 32'(bus.data_o), 32'd0);
    check("rst_overflow_o", 32'(bus.overflow_o), 32'd0);
    check("rst_max_skew_o", 32'(bus.max_skew_o), 32'd0);
    rst_ni = 1'b1;
    idle(2, 1'b1);

    // Zero skew: one word visible for exactly one cycle after the push.
    step('1, DW'(8'hA5), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("zero_skew_valid", 32'(bus.valid_o), 32'd1);
    check("zero_skew_data", 32'(bus.data_o), 32'hA5);
    step('0, '0, 1'b1, 1'b0);
    check("zero_skew_single", 32'(bus.valid_o), 32'd0);

    // Lane 0 leads by 3.
    stream(0, 3, 8, 1'b0);
    idle(2, 1'b1);

    // Backpressure until the fifth beat overflows, then flush back to RUN.
    for (int i = 0; i < 5; i++) step('1, DW'($urandom), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("bp_overflow", 32'(bus.overflow_o), 32'd1);
    check("bp_valid_low", 32'(bus.valid_o), 32'd0);
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b1, 1'b0);
    check("flush_overflow_clr", 32'(bus.overflow_o), 32'd0);
    check("flush_empty", 32'(bus.valid_o), 32'd0);
    step('1, DW'(8'h3C), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("post_flush_word", 32'(bus.data_o), 32'h3C);
    idle(1, 1'b1);

    // Full lanes with simultaneous pop and push.
    for (int i = 0; i < DEPTH; i++) step('1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step('1, DW'($urandom), 1'b1, 1'b0);
    check("full_pop_no_ovf", 32'(bus.overflow_o), 32'd0);
    idle(DEPTH + 1, 1'b1);

    // Lane 3 leads by 2.
    stream(3, 2, 6, 1'b0);
    idle(2, 1'b1);
`ifdef SERIAL_LINK_DESKEW_STATS_EN
    check("stats_max_skew", 32'(bus.max_skew_o), 32'd2);
    step('0, '0, 1'b1, 1'b1);
    step('0, '0, 1'b1, 1'b0);
    check("stats_flush_clr", 32'(bus.max_skew_o), 32'd0);
`endif

    // Random skewed streams and unconstrained random traffic.
    for (int k = 0; k < 20; k++) begin
      stream(-1, 0, int'($urandom_range(1, 10)), 1'b1);
      if (m_err) step('0, '0, 1'b1, 1'b1);
      idle(DEPTH, 1'b1);
    end
    for (int i = 0; i < 1500; i++) begin
      logic [NL-1:0] lv;
      lv = ($urandom_range(0, 3) != 0) ? '1 : NL'($urandom);
      step(lv, DW'($urandom), $urandom_range(0, 4) != 0,
           m_err ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0));
    end

    // Asynchronous reset in the middle of traffic.
    step('1, DW'($urandom), 1'b0, 1'b0);
    step('1, DW'($urandom), 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
    check("midrst_data_o", 32'(bus.data_o), 32'd0);
    check("midrst_overflow_o", 32'(bus.overflow_o), 32'd0);
    status_q.delete();
    word_q.delete();
    model_clear();
    repeat (2) @(posedge clk);
    bus.lane_valid_i = '0;
    bus.ready_i      = 1'b1;
    bus.flush_i      = 1'b0;
    #2;
    rst_ni = 1'b1;
    step({1'b0, {(NL-1){1'b1}}}, DW'($urandom), 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b0);
    check("postrst_partial_invalid", 32'(bus.valid_o), 32'd0);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0) ? '1 : NL'($urandom), DW'($urandom),
           $urandom_range(0, 4) != 0, m_err ? 1'b1 : 1'b0);

    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("words_drained", 32'(word_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
